// File: rtl/traffic_controller.sv
// rtl/traffic_controller.sv - two-way traffic light FSM with per-phase dwell timing
module traffic_controller #(
  parameter int unsigned GREEN_TIME  = 5,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] NS,
  output logic [2:0] EW
);

  typedef enum logic [2:0] {
    NS_GREEN, NS_YELLOW, ALLRED_A, EW_GREEN, EW_YELLOW, ALLRED_B
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [7:0] GREEN_LAST  = 8'(GREEN_TIME - 1);
  localparam logic [7:0] YELLOW_LAST = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ALLRED_LAST = 8'(ALLRED_TIME - 1);

  state_t     state_q, state_d, state_next;
  logic [7:0] cnt_q, cnt_d, cnt_last;
  logic [2:0] ns_q, ns_d, ew_q, ew_d;

  always_comb begin
    cnt_last   = ALLRED_LAST;
    state_next = NS_GREEN;
    case (state_q)
      NS_GREEN:  begin cnt_last = GREEN_LAST;  state_next = NS_YELLOW; end
      NS_YELLOW: begin cnt_last = YELLOW_LAST; state_next = ALLRED_A;  end
      ALLRED_A:  begin cnt_last = ALLRED_LAST; state_next = EW_GREEN;  end
      EW_GREEN:  begin cnt_last = GREEN_LAST;  state_next = EW_YELLOW; end
      EW_YELLOW: begin cnt_last = YELLOW_LAST; state_next = ALLRED_B;  end
      ALLRED_B:  begin cnt_last = ALLRED_LAST; state_next = NS_GREEN;  end
      default:   begin cnt_last = 8'd0;        state_next = ALLRED_B;  end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 8'd1;
    if (cnt_q == cnt_last) begin
      state_d = state_next;
      cnt_d   = 8'd0;
    end
  end

  // Lamps are decoded from the next state so the lamp flops always mirror state_q.
  always_comb begin
    ns_d = RED;
    ew_d = RED;
    case (state_d)
      NS_GREEN:  ns_d = GREEN;
      NS_YELLOW: ns_d = YELLOW;
      EW_GREEN:  ew_d = GREEN;
      EW_YELLOW: ew_d = YELLOW;
      default: begin
        ns_d = RED;
        ew_d = RED;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ALLRED_B;
      cnt_q   <= 8'd0;
      ns_q    <= RED;
      ew_q    <= RED;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign NS = ns_q;
  assign EW = ew_q;

endmodule

// File: tb/tb_traffic_controller.sv
// tb/tb_traffic_controller.sv - directed-vector bench for traffic_controller
module tb_traffic_controller;

  logic       clk;
  logic       reset;
  logic [2:0] ns_def, ew_def, ns_fast, ew_fast;
  int         n_checks;
  int         n_pass;

  traffic_controller dut (
    .clk   (clk),
    .reset (reset),
    .NS    (ns_def),
    .EW    (ew_def)
  );

  traffic_controller #(
    .GREEN_TIME  (1),
    .YELLOW_TIME (1),
    .ALLRED_TIME (1)
  ) dut_fast (
    .clk   (clk),
    .reset (reset),
    .NS    (ns_fast),
    .EW    (ew_fast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {NS, EW} expected after edge k is exp16[(k-1)%16] / exp6[(k-1)%6]
  logic [5:0] exp16 [16];
  logic [5:0] exp6  [6];

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b required %b", tag, obs, exp);
  endtask

  function automatic logic legal(input logic [2:0] l);
    return (l == 3'b100) || (l == 3'b010) || (l == 3'b001);
  endfunction

  task automatic trace(input string tag, input int edges);
    for (int k = 1; k <= edges; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s_def_e%0d", tag, k), {ns_def, ew_def}, exp16[(k-1)%16]);
      check($sformatf("%s_fast_e%0d", tag, k), {ns_fast, ew_fast}, exp6[(k-1)%6]);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 5; i++) exp16[i] = 6'b001_100;
    exp16[5]  = 6'b010_100;
    exp16[6]  = 6'b010_100;
    exp16[7]  = 6'b100_100;
    for (int i = 8; i < 13; i++) exp16[i] = 6'b100_001;
    exp16[13] = 6'b100_010;
    exp16[14] = 6'b100_010;
    exp16[15] = 6'b100_100;
    exp6[0] = 6'b001_100;
    exp6[1] = 6'b010_100;
    exp6[2] = 6'b100_100;
    exp6[3] = 6'b100_001;
    exp6[4] = 6'b100_010;
    exp6[5] = 6'b100_100;

    // Asynchronous reset at power-up, observed before the first clock edge
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("rst_async_def", {ns_def, ew_def}, 6'b100_100);
    check("rst_async_fast", {ns_fast, ew_fast}, 6'b100_100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_hold_%0d", c), {ns_def, ew_def}, 6'b100_100);
    end
    reset = 1'b1;
    trace("run1", 32);

    // Mid-operation reset: re-align so the next edge is edge 1, run into EW_GREEN
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 11; k++) @(posedge clk);
    #1;
    check("pre_rst_ewgreen", {ns_def, ew_def}, 6'b100_001);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_def", {ns_def, ew_def}, 6'b100_100);
    check("mid_rst_fast", {ns_fast, ew_fast}, 6'b100_100);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("mid_rst_hold_%0d", c), {ns_def, ew_def}, 6'b100_100);
    end
    reset = 1'b1;
    trace("run2", 32);

    // Long run with sporadic asynchronous resets: lamp legality and mutual exclusion
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      #($urandom_range(0, 3));
      reset = ($urandom_range(0, 49) != 0);
      #1;
      check("legal_def", {5'd0, legal(ns_def) && legal(ew_def)}, 6'd1);
      check("excl_def", {5'd0, (ns_def != 3'b100) && (ew_def != 3'b100)}, 6'd0);
      check("legal_fast", {5'd0, legal(ns_fast) && legal(ew_fast)}, 6'd1);
      check("excl_fast", {5'd0, (ns_fast != 3'b100) && (ew_fast != 3'b100)}, 6'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
